// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//    Instruction fetch stage.  It fetches one word at a time from instruction
//    memory and presents it to the control decoder with a valid/ready handshake.
//    A redirect (branch/jump) input overrides everything else and restarts
//    fetching at the word-aligned target.
//
// Parameters:
//    RESET_PC    - first fetch address after reset (expected to be word aligned)
//
// Ports:
//    clk         - single clock, all state updates on the rising edge
//    rst         - asynchronous active-high reset
//    imem_req    - instruction memory read request (high in FETCH only)
//    imem_addr   - word-aligned read address, always equal to pc
//    imem_ack    - memory response valid for the address of this cycle
//    imem_rdata  - memory read data, valid when imem_ack=1
//    inst        - instruction word for the decoder
//    inst_pc     - address of the word on inst
//    inst_valid  - inst / inst_pc are valid
//    inst_ready  - decoder accepts inst this cycle
//    redirect    - branch/jump redirect request
//    redirect_pc - redirect target (low two bits ignored)
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;

   // State register.  Reset is asynchronous so that a reset pulse between
   // clock edges removes any valid instruction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= 32'h00000000;
         inst_pc_q    <= RESET_PC;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   // Next-state logic.  Redirect is checked first so that an ack in the same
   // cycle is dropped (no capture, no pc increment).  In HOLD a coincident
   // inst_ready needs no special handling: the word is simply considered
   // consumed and the redirect target becomes the next fetch address.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;

      if (redirect) begin
         pc_d         = {redirect_pc[31:2], 2'b00};
         inst_valid_d = 1'b0;
         state_d      = FETCH;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  inst_d       = imem_rdata;
                  inst_pc_d    = pc_q;
                  pc_d         = pc_q + 32'd4;   // wraps modulo 2^32
                  inst_valid_d = 1'b1;
                  state_d      = HOLD;
               end
            end
            HOLD: begin
               if (inst_ready) begin
                  inst_valid_d = 1'b0;
                  state_d      = FETCH;
               end
            end
            default: begin
               state_d      = IDLE;
               inst_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Outputs come straight from registered state, so imem_addr is stable for
   // the whole wait in FETCH and inst is held while the decoder stalls.
   assign imem_req   = (state_q == FETCH);
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Purpose:
//    Self-checking bench for inst_fetch: a table of directed vectors covering
//    the main fetch/hold/redirect/wrap cases, hand-written asynchronous reset
//    sequences, and a randomized run checked against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int n_compared;
   int n_failed;

   inst_fetch #(.RESET_PC(32'h00000000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_failed++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                          input logic e_valid, input logic [31:0] e_inst,
                          input logic [31:0] e_pc);
      chk({tag, ".imem_req"},   {31'd0, imem_req},   {31'd0, e_req});
      chk({tag, ".imem_addr"},  imem_addr,           e_addr);
      chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_valid});
      chk({tag, ".inst"},       inst,                e_inst);
      chk({tag, ".inst_pc"},    inst_pc,             e_pc);
   endtask

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        ready;
      logic        redir;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[20];

   // Transaction-level reference: "waiting" is the single post-reset idle
   // cycle; otherwise the fetcher is requesting exactly when it holds no word.
   logic        m_waiting;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_inst_pc;

   initial begin
      n_compared  = 0;
      n_failed    = 0;
      rst         = 1'b1;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      inst_ready  = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      //            ack rdata          rdy red rpc            req addr           vld inst           inst_pc
      vecs[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b0, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
      vecs[1]  = '{1'b1, 32'h4FE00000, 1'b1, 1'b0, 32'h0,       1'b1, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
      vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b0, 32'h00000004, 1'b1, 32'h4FE00000, 32'h00000000};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b1, 32'h00000004, 1'b0, 32'h4FE00000, 32'h00000000};
      vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b1, 32'h00000004, 1'b0, 32'h4FE00000, 32'h00000000};
      vecs[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b1, 32'h00000004, 1'b0, 32'h4FE00000, 32'h00000000};
      vecs[6]  = '{1'b1, 32'h48012CB2, 1'b1, 1'b0, 32'h0,       1'b1, 32'h00000004, 1'b0, 32'h4FE00000, 32'h00000000};
      vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[8]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[10] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,       1'b0, 32'h00000008, 1'b1, 32'h48012CB2, 32'h00000004};
      vecs[13] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h00000103, 1'b1, 32'h00000008, 1'b0, 32'h48012CB2, 32'h00000004};
      vecs[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h00000100, 1'b0, 32'h48012CB2, 32'h00000004};
      vecs[15] = '{1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,       1'b1, 32'hFFFFFFFC, 1'b0, 32'h48012CB2, 32'h00000004};
      vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h00000200, 1'b0, 32'h00000000, 1'b1, 32'h12345678, 32'hFFFFFFFC};
      vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b1, 32'h00000200, 1'b0, 32'h12345678, 32'hFFFFFFFC};
      vecs[18] = '{1'b1, 32'hAAAA5555, 1'b0, 1'b0, 32'h0,       1'b1, 32'h00000200, 1'b0, 32'h12345678, 32'hFFFFFFFC};
      vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,       1'b0, 32'h00000204, 1'b1, 32'hAAAA5555, 32'h00000200};

      // Reset values while rst is held.
      repeat (2) @(negedge clk);
      chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;

      // Directed table; outputs depend only on registered state, so inputs
      // and checks share the falling edge.
      for (int i = 0; i < 20; i++) begin
         imem_ack    = vecs[i].ack;
         imem_rdata  = vecs[i].rdata;
         inst_ready  = vecs[i].ready;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                 vecs[i].e_valid, vecs[i].e_inst, vecs[i].e_pc);
         $display("vec %0d: ack=%0b ready=%0b redirect=%0b -> req=%0b addr=%08h valid=%0b inst=%08h pc=%08h",
                  i, vecs[i].ack, vecs[i].ready, vecs[i].redir, imem_req, imem_addr,
                  inst_valid, inst, inst_pc);
         @(negedge clk);
      end

      // Asynchronous reset pulse between edges while holding a word.
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      redirect   = 1'b0;
      @(posedge clk);
      #2;
      chk("hold_pre_rst.inst_valid", {31'd0, inst_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk_all("async_rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      $display("async reset in HOLD: valid=%0b req=%0b addr=%08h", inst_valid, imem_req, imem_addr);
      // Acks during reset must be ignored.
      imem_ack   = 1'b1;
      imem_rdata = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      chk_all("rst_ack_ignored", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      rst      = 1'b0;
      imem_ack = 1'b0;
      chk("post_rst_idle.imem_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      chk_all("post_rst_fetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

      // Reset arriving mid-fetch together with an ack: nothing captured.
      imem_ack   = 1'b1;
      imem_rdata = 32'hBADC0DE0;
      rst        = 1'b1;
      @(negedge clk);
      rst      = 1'b0;
      imem_ack = 1'b0;
      chk_all("rst_mid_fetch", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      $display("reset mid-fetch: valid=%0b inst=%08h", inst_valid, inst);

      // Randomized run against the transaction model.
      m_waiting = 1'b1;
      m_pc      = 32'h0;
      m_valid   = 1'b0;
      m_inst    = 32'h0;
      m_inst_pc = 32'h0;
      for (int c = 0; c < 400; c++) begin
         chk_all($sformatf("rnd%0d", c), !m_waiting && !m_valid, m_pc, m_valid, m_inst, m_inst_pc);
         imem_ack    = ($urandom_range(0, 1) == 1);
         imem_rdata  = $urandom;
         inst_ready  = ($urandom_range(0, 1) == 1);
         redirect    = ($urandom_range(0, 9) == 0);
         redirect_pc = $urandom;
         if (m_valid && inst_ready)
            $display("rnd %0d: consumed inst=%08h pc=%08h", c, m_inst, m_inst_pc);
         if (redirect) begin
            m_pc      = redirect_pc & 32'hFFFFFFFC;
            m_valid   = 1'b0;
            m_waiting = 1'b0;
         end else if (m_waiting) begin
            m_waiting = 1'b0;
         end else if (!m_valid) begin
            if (imem_ack) begin
               m_inst    = imem_rdata;
               m_inst_pc = m_pc;
               m_pc      = m_pc + 32'd4;
               m_valid   = 1'b1;
            end
         end else if (inst_ready) begin
            m_valid = 1'b0;
         end
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
